// File: rtl/cwt_pkg.sv
// Shared constants, sample type and width helper for the CWT datapath blocks.
package cwt_pkg;

   localparam int CWT_SAMPLE_BITS = 16;
   localparam int CWT_NUM_TAPS    = 64;

   typedef logic [CWT_SAMPLE_BITS-1:0] cwt_sample_t;

   // Counter width for a modulus v; never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/cwt_stride_ctr.sv
// Fill-level saturation, stride counter and frame_valid pulse for the CWT window.
module cwt_stride_ctr
   import cwt_pkg::*;
#(
   parameter int NUM_REGS = CWT_NUM_TAPS,
   parameter int STRIDE   = 1,
   localparam int FW      = $clog2(NUM_REGS + 1),
   localparam int SW      = clog2_min1(STRIDE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          accept,
   output logic [FW-1:0] fill_count,
   output logic [SW-1:0] stride_cnt,
   output logic          frame_valid
);

   localparam logic [FW-1:0] FULL        = FW'(NUM_REGS);
   localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);

   logic [FW-1:0] nf;

   assign nf = (fill_count == FULL) ? fill_count : fill_count + 1'b1;

   // Only an accepted sample can raise frame_valid, so every other cycle clears it.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         fill_count  <= '0;
         stride_cnt  <= '0;
         frame_valid <= 1'b0;
      end else if (accept) begin
         fill_count <= nf;
         if (nf == FULL) begin
            frame_valid <= (stride_cnt == '0);
            stride_cnt  <= (stride_cnt == STRIDE_LAST) ? '0 : stride_cnt + 1'b1;
         end else begin
            frame_valid <= 1'b0;
            stride_cnt  <= '0;
         end
      end else begin
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/cwt_window_regfile.sv
// Sliding-window sample bank: serial shift-in with strided frame pulses plus parallel preload.
// Optional synchronous clear input enabled by defining CWT_WINDOW_CLEAR_EN.
module cwt_window_regfile
   import cwt_pkg::*;
#(
   parameter int NUM_REGS = CWT_NUM_TAPS,
   parameter int BITS     = CWT_SAMPLE_BITS,
   parameter int STRIDE   = 1,
   localparam int FW      = $clog2(NUM_REGS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef CWT_WINDOW_CLEAR_EN
   input  logic                     clear,
`endif
   input  logic [NUM_REGS-1:0]      wr_en,
   input  logic [NUM_REGS*BITS-1:0] wr_data,
   input  logic                     shift_valid,
   input  logic [BITS-1:0]          shift_data,
   output logic                     shift_ready,
   input  logic                     freeze,
   output logic [NUM_REGS*BITS-1:0] rd_data,
   output logic [FW-1:0]            fill_count,
   output logic                     window_full,
   output logic                     frame_valid
);

   localparam int SW = clog2_min1(STRIDE);

   logic            clr;
   logic            accept;
   logic [SW-1:0]   stride_cnt;
   logic [BITS-1:0] entry [NUM_REGS];

`ifdef CWT_WINDOW_CLEAR_EN
   assign clr = clear;
`else
   assign clr = 1'b0;
`endif

   // Handshake: a sample transfers on a rising edge where shift_valid && shift_ready;
   // ready depends only on freeze/wr_en/clear, never on shift_valid, so a held valid
   // transfers once per accepting edge and shift_data is ignored otherwise.
   assign shift_ready = !freeze && !(|wr_en) && !clr;
   assign accept      = shift_valid && shift_ready;
   assign window_full = (fill_count == FW'(NUM_REGS));

   // accept already excludes wr_en, so the two update paths are mutually exclusive.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < NUM_REGS; i++) entry[i] <= '0;
      end else if (accept) begin
         entry[0] <= shift_data;
         for (int i = 1; i < NUM_REGS; i++) entry[i] <= entry[i-1];
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en[i]) entry[i] <= wr_data[i*BITS +: BITS];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_rd
      assign rd_data[g*BITS +: BITS] = entry[g];
   end

   cwt_stride_ctr #(
      .NUM_REGS (NUM_REGS),
      .STRIDE   (STRIDE)
   ) u_stride_ctr (
      .clk         (clk),
      .rst         (rst),
      .clear       (clr),
      .accept      (accept),
      .fill_count  (fill_count),
      .stride_cnt  (stride_cnt),
      .frame_valid (frame_valid)
   );

endmodule
